decode_ram_scheduler: RTL and testbench

Sequences the single-port decoded-data RAM that sits behind the LDPC decoder in the receiver. It shares the one RAM port between two requesters: decoder write-back (one byte per rising edge of the decoder valid flag) and a UART readout stream (one byte per TX handshake). It also tracks frame fill and completion, and paces readout bytes. It replaces the free-running write-address counter and the ad-hoc readout loop around the decoded-data RAM.

---
 rtl/drs_pkg.sv | 18 +
 rtl/decode_ram_scheduler_rise_detect.sv | 22 ++
 rtl/decode_ram_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_decode_ram_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drs_pkg.sv
// Shared types and defaults for the decoded-data RAM scheduler.
// Optional feature macro: DRS_PACING_EN (inserts a GAP state between readout bytes).
package drs_pkg;

  // Readout FSM states. Explicit encoding keeps debug traces readable.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_OFFER   = 3'd3,
    ST_GAP     = 3'd4
  } drs_state_e;

  localparam int DRS_FRAME_BYTES = 121;
  localparam int DRS_GAP_CYCLES  = 10;
  localparam int DRS_DROP_W      = 8;

endpackage

// File: rtl/decode_ram_scheduler_rise_detect.sv
// Rising-edge detector: registers a level and pulses for one cycle on 0->1.
module rise_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_level,
  output logic o_pulse
);

  logic r_level;

  // Previous-cycle copy of the level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_level <= 1'b0;
    end else begin
      r_level <= i_level;
    end
  end

  assign o_pulse = i_level & ~r_level;

endmodule

// File: rtl/decode_ram_scheduler.sv
// Scheduler for the single-port decoded-data RAM behind the LDPC decoder.
// Decoder write-back (one byte per dec_valid rising edge) and UART readout
// share the RAM port; writes always win and reads retry in ISSUE.
// Optional feature macro: DRS_PACING_EN (GAP_CYCLES idle cycles between bytes).
//
// TX handshake: a byte transfers on a rising clock edge where tx_valid and
// tx_ready are both 1; tx_valid/tx_data stay stable from assertion until then,
// and tx_valid never drops without a transfer (except on reset).
module decode_ram_scheduler
  import drs_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 8,
  parameter int FRAME_BYTES = DRS_FRAME_BYTES,
  parameter int GAP_CYCLES  = DRS_GAP_CYCLES
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic                  dec_valid,
  input  logic [DATA_W-1:0]     dec_data,
  input  logic                  unload,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [DATA_W-1:0]     tx_data,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  output logic                  ram_wren,
  input  logic [DATA_W-1:0]     ram_q,
  output logic                  frame_full,
  output logic                  frame_done,
  output logic [DRS_DROP_W-1:0] drop_cnt,
  output drs_state_e            dbg_state
);

  // One extra bit so a pointer can hold FRAME_BYTES == 2**ADDR_W.
  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] FRAME_END = PTR_W'(FRAME_BYTES);

  logic                  w_rise;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_frame_full;
  logic                  w_frame_done;
  logic                  w_tx_hs;
  logic                  w_rd_ok;
  logic                  w_rd_ok_after;
  logic [PTR_W-1:0]      w_rd_ptr_inc;

  logic                  r_wpend;
  logic [DATA_W-1:0]     r_wbuf;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [DRS_DROP_W-1:0] r_drop_cnt;
  logic                  r_tx_valid;
  logic [DATA_W-1:0]     r_tx_data;
  drs_state_e            r_state;
  drs_state_e            w_next_state;

  rise_detect u_rise_detect (
    .i_clk   (CLOCK_50),
    .i_rst_n (reset_n),
    .i_level (dec_valid),
    .o_pulse (w_rise)
  );

  assign w_frame_full  = (r_wr_ptr == FRAME_END);
  assign w_frame_done  = (r_rd_ptr == FRAME_END);
  assign w_accept      = w_rise & ~w_frame_full;
  assign w_drop        = w_rise &  w_frame_full;
  assign w_tx_hs       = (r_state == ST_OFFER) & r_tx_valid & tx_ready;
  assign w_rd_ptr_inc  = r_rd_ptr + PTR_W'(1);

  // Readout may start only on bytes already committed to RAM.
  assign w_rd_ok       = unload & (r_rd_ptr < r_wr_ptr) & ~w_frame_done;
  // Same test as seen after the pointer bump of a handshake in progress;
  // lets the IDLE decision be taken on the way out of OFFER/GAP for free.
  assign w_rd_ok_after = unload & (w_rd_ptr_inc < r_wr_ptr) & (w_rd_ptr_inc != FRAME_END);

  // One-entry write buffer and write pointer; the buffered byte owns the port next cycle.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_wpend  <= 1'b0;
      r_wbuf   <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (r_wpend) begin
        r_wpend  <= 1'b0;
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_accept) begin
        r_wpend <= 1'b1;
        r_wbuf  <= dec_data;
      end
    end
  end

  // Saturating count of write requests discarded while the frame is full.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != {DRS_DROP_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + DRS_DROP_W'(1);
    end
  end

  // Read pointer advances only on a completed TX handshake.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
    end else if (w_tx_hs) begin
      r_rd_ptr <= w_rd_ptr_inc;
    end
  end

  // TX holding register: loaded from RAM in CAPTURE, released on handshake.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else if (r_state == ST_CAPTURE) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= ram_q;
    end else if (w_tx_hs) begin
      r_tx_valid <= 1'b0;
    end
  end

`ifdef DRS_PACING_EN
  logic [15:0] r_gap_cnt;

  // Counts cycles spent in GAP; cleared in every other state.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_gap_cnt <= '0;
    end else if (r_state == ST_GAP) begin
      r_gap_cnt <= r_gap_cnt + 16'd1;
    end else begin
      r_gap_cnt <= '0;
    end
  end
`else
  logic w_unused_gap;
  assign w_unused_gap = (GAP_CYCLES != 0);
`endif

  // FSM state register.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rd_ok) w_next_state = ST_ISSUE;
      end
      ST_ISSUE: begin
        // A pending write holds the port this cycle; retry the read next cycle.
        if (!r_wpend) w_next_state = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_next_state = ST_OFFER;
      end
      ST_OFFER: begin
        if (w_tx_hs) begin
`ifdef DRS_PACING_EN
          if (GAP_CYCLES > 0) w_next_state = ST_GAP;
          else                w_next_state = w_rd_ok_after ? ST_ISSUE : ST_IDLE;
`else
          w_next_state = w_rd_ok_after ? ST_ISSUE : ST_IDLE;
`endif
        end
      end
      ST_GAP: begin
`ifdef DRS_PACING_EN
        if (r_gap_cnt == 16'(GAP_CYCLES - 1)) w_next_state = w_rd_ok ? ST_ISSUE : ST_IDLE;
`else
        w_next_state = ST_IDLE;
`endif
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM/port outputs: the write buffer has priority on the RAM address.
  always_comb begin
    ram_wren   = r_wpend;
    ram_wdata  = r_wbuf;
    ram_addr   = '0;
    if (r_wpend) begin
      ram_addr = r_wr_ptr[ADDR_W-1:0];
    end else if (r_state == ST_ISSUE) begin
      ram_addr = r_rd_ptr[ADDR_W-1:0];
    end
    tx_valid   = r_tx_valid;
    tx_data    = r_tx_data;
    frame_full = w_frame_full;
    frame_done = w_frame_done;
    drop_cnt   = r_drop_cnt;
    dbg_state  = r_state;
  end

endmodule

// File: tb/tb_decode_ram_scheduler.sv
// Self-checking bench for decode_ram_scheduler: RAM model, scoreboard of
// written bytes, vector table of fill/readout scenarios, directed corner cases.
module tb_decode_ram_scheduler;
  import drs_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int FB     = 121;
  localparam int GAP    = 10;
`ifdef DRS_PACING_EN
  localparam int PERIOD = 3 + GAP;
`else
  localparam int PERIOD = 3;
`endif

  // ---------------- clock / reset ----------------
  logic              CLOCK_50 = 1'b0;
  logic              reset_n  = 1'b0;
  logic              dec_valid = 1'b0;
  logic [DATA_W-1:0] dec_data  = '0;
  logic              unload    = 1'b0;
  logic              tx_ready  = 1'b0;
  logic [DATA_W-1:0] ram_q     = '0;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_wren;
  logic              frame_full;
  logic              frame_done;
  logic [7:0]        drop_cnt;
  drs_state_e        dbg_state;

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  decode_ram_scheduler #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_BYTES(FB), .GAP_CYCLES(GAP)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset_n    (reset_n),
    .dec_valid  (dec_valid),
    .dec_data   (dec_data),
    .unload     (unload),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_wren   (ram_wren),
    .ram_q      (ram_q),
    .frame_full (frame_full),
    .frame_done (frame_done),
    .drop_cnt   (drop_cnt),
    .dbg_state  (dbg_state)
  );

  // Single-port RAM: synchronous write, data out one cycle after address.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge CLOCK_50) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  // ---------------- scoreboard / model ----------------
  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               exp_wr_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  model_acc = 0;
  int  model_drop = 0;
  int  wr_done = 0;
  int  rd_done = 0;
  int  last_hs = -1;
  bit  check_period = 1'b0;
  bit  prev_valid = 1'b0;
  bit  prev_hs = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor, sampled on the falling edge.
  initial begin
    logic exp_wren;
    logic hs;
    logic [DATA_W-1:0] e;
    forever begin
      @(negedge CLOCK_50);
      if (reset_n) begin
        while (exp_wr_q.size() > 0 && exp_wr_q[0].cyc < cyc) void'(exp_wr_q.pop_front());
        exp_wren = (exp_wr_q.size() > 0) && (exp_wr_q[0].cyc == cyc);
        check("ram_wren", ram_wren, exp_wren);
        check("frame_full", frame_full, wr_done >= FB);
        check("frame_done", frame_done, rd_done >= FB);
        if (exp_wren) begin
          check("wr_addr", ram_addr, exp_wr_q[0].addr);
          check("wr_data", ram_wdata, exp_wr_q[0].data);
          void'(exp_wr_q.pop_front());
          wr_done++;
        end
        hs = tx_valid && tx_ready;
        if (prev_valid && !prev_hs) begin
          check("tx_valid_hold", tx_valid, 1);
          check("tx_data_hold", tx_data, prev_data);
        end
        if (hs) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tx_unexpected: got byte 0x%0h with no written byte outstanding (cycle %0d)", tx_data, cyc);
          end else begin
            e = exp_q.pop_front();
            check("tx_data", tx_data, e);
          end
          if (check_period && last_hs >= 0) check("hs_period", cyc - last_hs, PERIOD);
          last_hs = cyc;
          rd_done++;
        end
        prev_valid = tx_valid;
        prev_hs    = hs;
        prev_data  = tx_data;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  // One dec_valid pulse; data changes after the edge cycle to prove sampling.
  task automatic pulse(input logic [DATA_W-1:0] d, input int hold, input int low);
    wr_t w;
    dec_valid = 1'b1;
    dec_data  = d;
    if (model_acc < FB) begin
      w.cyc  = cyc + 1;
      w.addr = ADDR_W'(model_acc);
      w.data = d;
      exp_wr_q.push_back(w);
      exp_q.push_back(d);
      model_acc++;
    end else if (model_drop < 255) begin
      model_drop++;
    end
    step();
    dec_data = DATA_W'($urandom);
    repeat (hold - 1) step();
    dec_valid = 1'b0;
    repeat (low) step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    exp_wr_q.delete();
    exp_q.delete();
    model_acc = 0; model_drop = 0; wr_done = 0; rd_done = 0;
    last_hs = -1; check_period = 1'b0; prev_valid = 1'b0; prev_hs = 1'b0;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_ram_wren", ram_wren, 0);
    check("rst_frame_full", frame_full, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_state", dbg_state, ST_IDLE);
    dec_valid = 1'b0; unload = 1'b0; tx_ready = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic wait_rd(input int n, input int budget);
    int k = 0;
    while (rd_done < n && k < budget) begin
      step();
      k++;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int n_wr;
    bit unload;
    int exp_tx;
    int exp_drop;
    bit exp_full;
    bit exp_done;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int c0;
    int k;

    vecs[0] = '{n_wr: 0,   unload: 1, exp_tx: 0,   exp_drop: 0,   exp_full: 0, exp_done: 0};
    vecs[1] = '{n_wr: 2,   unload: 1, exp_tx: 2,   exp_drop: 0,   exp_full: 0, exp_done: 0};
    vecs[2] = '{n_wr: 7,   unload: 0, exp_tx: 0,   exp_drop: 0,   exp_full: 0, exp_done: 0};
    vecs[3] = '{n_wr: 121, unload: 0, exp_tx: 0,   exp_drop: 0,   exp_full: 1, exp_done: 0};
    vecs[4] = '{n_wr: 124, unload: 0, exp_tx: 0,   exp_drop: 3,   exp_full: 1, exp_done: 0};
    vecs[5] = '{n_wr: 124, unload: 1, exp_tx: 121, exp_drop: 3,   exp_full: 1, exp_done: 1};
    vecs[6] = '{n_wr: 381, unload: 0, exp_tx: 0,   exp_drop: 255, exp_full: 1, exp_done: 0};

    for (int i = 0; i < 7; i++) begin
      do_reset();
      unload   = vecs[i].unload;
      tx_ready = 1'b1;
      for (int j = 0; j < vecs[i].n_wr; j++)
        pulse(DATA_W'($urandom), $urandom_range(1, 3), $urandom_range(1, 3));
      wait_rd(vecs[i].exp_tx, 3000);
      repeat (2 * PERIOD + 5) step();
      check($sformatf("vec%0d_tx_count", i), rd_done, vecs[i].exp_tx);
      check($sformatf("vec%0d_drop_cnt", i), drop_cnt, vecs[i].exp_drop);
      check($sformatf("vec%0d_frame_full", i), frame_full, vecs[i].exp_full);
      check($sformatf("vec%0d_frame_done", i), frame_done, vecs[i].exp_done);
    end

    // dec_valid held high: exactly one write.
    do_reset();
    pulse(8'hA5, 12, 2);
    repeat (3) step();
    check("long_hold_writes", wr_done, 1);

    // Fill 0x00..0x78, overflow by 3, then full readout at line rate.
    do_reset();
    for (int i = 0; i < FB; i++) pulse(DATA_W'(i), 1, 1);
    for (int i = 0; i < 3; i++) pulse(8'hEE, 1, 1);
    repeat (2) step();
    check("overflow_drop_cnt", drop_cnt, 3);
    check("overflow_writes", wr_done, FB);
    check_period = 1'b1;
    unload = 1'b1;
    tx_ready = 1'b1;
    wait_rd(FB, 3000);
    repeat (3) step();
    check_period = 1'b0;
    check("full_readout_count", rd_done, FB);
    check("full_readout_done", frame_done, 1);

    // Write edge in the same cycle as ISSUE: read slips one cycle.
    do_reset();
    pulse(8'h11, 1, 2);
    c0 = cyc;
    unload = 1'b1;
    pulse(8'h22, 1, 1);
    while (cyc < c0 + 3) @(negedge CLOCK_50);
    check("collision_slip", tx_valid, 0);
    @(negedge CLOCK_50);
    check("collision_valid", tx_valid, 1);
    check("collision_data", tx_data, 8'h11);
    #1;
    step();
    tx_ready = 1'b1;
    wait_rd(2, 100);
    check("collision_count", rd_done, 2);

    // Chase the writer, then backpressure.
    do_reset();
    unload = 1'b1;
    tx_ready = 1'b1;
    pulse(8'h3C, 1, 1);
    pulse(8'hC3, 1, 1);
    wait_rd(2, 100);
    repeat (10) step();
    check("chase_count", rd_done, 2);
    check("chase_idle_state", dbg_state, ST_IDLE);
    check("chase_idle_valid", tx_valid, 0);
    tx_ready = 1'b0;
    pulse(8'h5A, 1, 1);
    k = 0;
    while (!tx_valid && k < 20) begin step(); k++; end
    repeat (20) step();
    check("bp_valid", tx_valid, 1);
    check("bp_data", tx_data, 8'h5A);
    tx_ready = 1'b1;
    wait_rd(3, 50);
    check("bp_count", rd_done, 3);

    // Reset mid-readout near byte 50, then refill from address 0.
    do_reset();
    for (int i = 0; i < FB; i++) pulse(DATA_W'($urandom), 1, 1);
    unload = 1'b1;
    tx_ready = 1'b1;
    wait_rd(50, 2000);
    check("mid_reset_reached", rd_done, 50);
    step();
    do_reset();
    unload = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) pulse(DATA_W'($urandom), 1, 2);
    wait_rd(3, 200);
    repeat (5) step();
    check("refill_count", rd_done, 3);

    // Random traffic: unload and tx_ready toggle between writes.
    do_reset();
    for (int i = 0; i < 80; i++) begin
      unload   = ($urandom_range(0, 3) != 0);
      tx_ready = $urandom_range(0, 1);
      pulse(DATA_W'($urandom), $urandom_range(1, 4), $urandom_range(1, 4));
    end
    unload = 1'b1;
    tx_ready = 1'b1;
    wait_rd(model_acc, 3000);
    repeat (5) step();
    check("random_drain", rd_done, 80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog bounds the whole run.
  initial begin
    #(100000 * 20);
    $display("FAIL watchdog: run exceeded cycle budget at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
